// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and frame constants for uart_rx and uart_tx
package uart_pkg;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for rxd plus falling-edge detect (ports: clk, reset, rxd -> level, fall)
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rxd,
  output logic level,
  output logic fall
);
  logic [2:0] s_q, s_d;
  always_comb s_d = {s_q[1:0], rxd};
  always_ff @(posedge clk)
    s_q <= reset ? 3'b111 : s_d;
  assign level = s_q[1];
  assign fall  = s_q[2] & ~s_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, byte + valid strobe, frame error on low stop bit; UART_RX_MAJORITY_EN enables 2-of-3 bit voting
module uart_rx
  import uart_pkg::*;
#(
  parameter int clk_num  = 128000000,
  parameter int bps      = 512000,
  parameter int clk_max  = clk_num / bps - 1,
  parameter int clk_half = clk_max / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic [7:0] uart_data,
  output logic       data_vld,
  output logic       frame_err,
  output logic       rx_busy
);
`ifdef UART_RX_MAJORITY_EN
  localparam int DLY = 1;
`else
  localparam int DLY = 0;
`endif
  localparam logic [29:0] HALF_PT = 30'(clk_half + DLY);
  localparam logic [29:0] BIT_PT  = 30'(clk_max + DLY);
  localparam logic [29:0] RELOAD  = 30'(DLY);
  logic rx, fall, bit_v;
  state_t state_q, state_d;
  logic [29:0] clk_cnt_q, clk_cnt_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, uart_data_q, uart_data_d;
  logic data_vld_q, data_vld_d, frame_err_q, frame_err_d, rx_busy_q, rx_busy_d;
  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rxd   (uart_rxd),
    .level (rx),
    .fall  (fall)
  );
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q, hist_d;
  always_comb hist_d = {hist_q[0], rx};
  always_ff @(posedge clk)
    hist_q <= reset ? 2'b11 : hist_d;
  assign bit_v = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx) | (hist_q[0] & rx);
`else
  assign bit_v = rx;
`endif
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q + 30'd1;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    uart_data_d = uart_data_q;
    data_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        state_d   = fall ? START : IDLE;
      end
      START: if (clk_cnt_q == HALF_PT) begin
        state_d   = bit_v ? IDLE : DATA;
        clk_cnt_d = RELOAD;
      end
      DATA: if (clk_cnt_q == BIT_PT) begin
        shift_d   = {bit_v, shift_q[7:1]};
        clk_cnt_d = RELOAD;
        bit_cnt_d = bit_cnt_q + 4'd1;
        state_d   = (bit_cnt_q == 4'(DATA_BITS - 1)) ? STOP : DATA;
      end
      STOP: if (clk_cnt_q == BIT_PT) begin
        state_d     = bit_v ? IDLE : BRK;
        data_vld_d  = bit_v;
        frame_err_d = ~bit_v;
        uart_data_d = bit_v ? shift_q : uart_data_q;
      end
      BRK: begin
        clk_cnt_d = '0;
        state_d   = rx ? IDLE : BRK;
      end
      default: state_d = IDLE;
    endcase
    rx_busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      uart_data_q <= '0;
      data_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      uart_data_q <= uart_data_d;
      data_vld_q  <= data_vld_d;
      frame_err_q <= frame_err_d;
      rx_busy_q   <= rx_busy_d;
    end
  end
  assign uart_data = uart_data_q;
  assign data_vld  = data_vld_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = rx_busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for uart_rx with a bit-level serial transmitter model
module tb_uart_rx;
  localparam int P = 250;
  typedef struct {
    bit         err;
    logic [7:0] data;
    bit         lat;
    int         t0;
  } exp_t;
  logic clk = 0, reset = 1, uart_rxd = 1;
  logic [7:0] uart_data;
  logic data_vld, frame_err, rx_busy;
  int cyc = 0, total = 0, bad = 0;
  exp_t q[$];
  logic [7:0] last_good = 8'h00;
  bit busy_seen = 0, prev_vld = 0, prev_err = 0;
  uart_rx dut (
    .clk       (clk),
    .reset     (reset),
    .uart_rxd  (uart_rxd),
    .uart_data (uart_data),
    .data_vld  (data_vld),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h @cyc %0d", n, act, exp, cyc);
    end
  endtask
  task automatic drive(input logic v, input int p);
    uart_rxd = v;
    repeat (p) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input int p, input bit ok, input int gbit);
    exp_t e;
    e.err  = !ok;
    e.data = ok ? b : last_good;
    e.lat  = (p == P);
    e.t0   = cyc;
    if (ok) last_good = b;
    q.push_back(e);
    drive(1'b0, p);
    for (int i = 0; i < 8; i++)
      if (i == gbit) begin
        drive(b[i], p / 2);
        drive(~b[i], 1);
        drive(b[i], p - p / 2 - 1);
      end else drive(b[i], p);
    drive(ok, p);
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_busy) busy_seen = 1;
      if (data_vld && frame_err) chk("vld_and_err_together", 1, 0);
      if (data_vld && prev_vld) chk("vld_width", 2, 1);
      if (frame_err && prev_err) chk("err_width", 2, 1);
      if (data_vld || frame_err) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse vld=%0b err=%0b data=%0h", data_vld, frame_err, uart_data);
        end else begin
          exp_t e;
          int lat;
          e = q.pop_front();
          chk(data_vld ? "vld_kind" : "err_kind", int'(frame_err), int'(e.err));
          chk(data_vld ? "vld_data" : "err_held_data", int'(uart_data), int'(e.data));
          lat = cyc - e.t0;
          if (e.lat && data_vld) begin
            total++;
            if (lat < 2377 || lat > 2381) begin
              bad++;
              $display("FAIL latency act=%0d exp=2379+-2", lat);
            end
          end
        end
      end
      prev_vld = data_vld;
      prev_err = frame_err;
    end
  end
  initial begin
    int t0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", int'(uart_data), 0);
    chk("rst_vld", int'(data_vld), 0);
    chk("rst_err", int'(frame_err), 0);
    chk("rst_busy", int'(rx_busy), 0);
    @(posedge clk);
    #1 reset = 0;
    drive(1'b1, 2 * P);
    send(8'hA5, P, 1, -1);
    drive(1'b1, 2 * P);
    for (int i = 0; i < 10; i++) send(8'(i), P, 1, -1);
    drive(1'b1, 2 * P);
    send(8'h3C, P, 0, -1);
    drive(1'b0, 3 * P);
    drive(1'b1, 2 * P);
    send(8'h55, P, 1, -1);
    drive(1'b1, 2 * P);
    busy_seen = 0;
    t0 = cyc;
    drive(1'b0, 50);
    uart_rxd = 1;
    while (cyc - t0 < 130) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_seen", int'(busy_seen), 1);
    chk("glitch_busy_clear", int'(rx_busy), 0);
    @(posedge clk);
    #1 drive(1'b1, P);
    begin
      logic [7:0] ab;
      ab = 8'h5A;
      drive(1'b0, P);
      for (int i = 0; i < 4; i++) drive(ab[i], P);
      drive(ab[4], P / 2);
      chk("busy_mid_frame", int'(rx_busy), 1);
      reset = 1;
      uart_rxd = 1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_data", int'(uart_data), 0);
      chk("abort_vld", int'(data_vld), 0);
      chk("abort_err", int'(frame_err), 0);
      chk("abort_busy", int'(rx_busy), 0);
      @(posedge clk);
      #1 reset = 0;
      last_good = 8'h00;
    end
    drive(1'b1, 3 * P);
    send(8'hC3, P, 1, -1);
    drive(1'b1, 2 * P);
    send(8'h96, P + P / 50, 1, -1);
    drive(1'b1, 2 * P);
    send(8'h96, P - P / 50, 1, -1);
    drive(1'b1, 2 * P);
`ifdef UART_RX_MAJORITY_EN
    send(8'h96, P, 1, 2);
    drive(1'b1, 2 * P);
`endif
    for (int i = 0; i < 6; i++) begin
      int gap;
      gap = $urandom_range(0, 300);
      send(8'($urandom), P, 1, -1);
      if (gap > 0) drive(1'b1, gap);
    end
    drive(1'b1, 2 * P);
    for (int i = 0; i < 5000 && q.size() != 0; i++) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
